wb_arb: RTL and testbench
=========================

Name: wb_arb

Overview:
- Write-back arbiter and scoreboard that drives the GPR file's single write port.
- Merges two sources into one registered write per cycle:
  - single-cycle execute results
  - long-latency results (LSU load, divider) over a valid/ready handshake
- Keeps a per-register busy scoreboard so decode can stall on pending long-latency destinations.

Parameters:
- REG_NUM, 32, number of GPRs (16 when RV32E_BASE_ISA is defined)
- AW, 5, register address width
- DW, 32, data width
- FIFO_DEPTH, 2, long-latency result buffer entries (power of two, >=2)

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- ex_valid_i  in  1  execute result valid this cycle; never back-pressured
- ex_rd_i  in  AW  execute destination register
- ex_data_i  in  DW  execute result
- lt_issue_i  in  1  long-latency op issued this cycle
- lt_issue_rd_i  in  AW  its destination register
- lt_valid_i  in  1  long-latency result valid
- lt_ready_o  out  1  arbiter can accept a long-latency result
- lt_rd_i  in  AW  result destination
- lt_data_i  in  DW  result data
- we_o  out  1  GPR write enable
- waddr_o  out  AW  GPR write address
- wdata_o  out  DW  GPR write data
- rs1_i, rs2_i  in  AW  decode source registers
- rs1_busy_o, rs2_busy_o  out  1  source has a pending long-latency write
- waw_err_o  out  1  sticky hazard error flag

Behaviour:
- Reset (synchronous, rst=1 at posedge) clears:
  - outputs: we_o=0, waddr_o=0, wdata_o=0, waw_err_o=0
  - internal state: FIFO empty (pointers and count 0), all scoreboard bits 0
- Output register: we_o/waddr_o/wdata_o load every cycle, with this priority:
  1. ex_valid_i -> ex_rd_i/ex_data_i
  2. else FIFO non-empty -> FIFO head, popped
  3. else lt_valid_i && lt_ready_o -> lt input directly (FIFO bypass, not pushed)
  4. else we_o=0; waddr_o/wdata_o hold
- Latency: one cycle from acceptance to we_o=1. The GPR file writes on the edge after that.
- Long-latency acceptance and buffering:
  - Handshake completes when lt_valid_i && lt_ready_o.
  - lt_ready_o = (count < FIFO_DEPTH), combinational from count only; never depends on lt_valid_i.
  - An accepted result that is not bypassed is pushed.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Results are written in acceptance order.
- rd = 0:
  - The selected entry is consumed (popped or accepted) but we_o stays 0.
  - Scoreboard bit 0 is never set.
- Scoreboard:
  - busy[lt_issue_rd_i] is set on lt_issue_i when rd != 0.
  - busy[waddr_o] is cleared on the edge where we_o=1 and the source was long-latency. This is the same edge the GPR file writes, so busy never drops before the data is visible.
  - Set and clear of the same register in one cycle: set wins.
  - An execute write does not clear busy.
- Busy outputs: rsN_busy_o = busy[rsN_i], combinational; rsN_i = 0 always returns 0.
- waw_err_o sets and holds until rst on any of:
  - lt_issue_i to a register already busy
  - ex_valid_i with ex_rd_i busy
  - accepted lt result whose rd is not busy (rd != 0)
- Execute starvation: the long-latency path may stall while ex_valid_i stays high. This is permitted; lt_ready_o simply stays 0 when the FIFO is full.
- Reset mid-operation: buffered results are discarded and scoreboard bits cleared. Upstream units are reset by the same rst.

Decomposition:
- Shared defines: RegAddrBus and RegBus widths; RV32E_BASE_ISA selects REG_NUM.
- Local constants: source-select encoding (SRC_NONE, SRC_EX, SRC_FIFO, SRC_BYP).
- One sub-module: wb_fifo (synchronous FIFO, depth FIFO_DEPTH, width AW+DW, push/pop/full/empty/count).
- Scoreboard and arbitration stay in wb_arb.

Test Plan:
- Reset: hold rst=1 for 2 cycles with ex_valid_i=1 -> we_o=0, lt_ready_o=1, all busy=0, waw_err_o=0.
- Execute only: ex_valid_i=1, ex_rd_i=5, ex_data_i=32'hDEADBEEF at cycle N -> we_o=1, waddr_o=5, wdata_o=32'hDEADBEEF at N+1; we_o=0 at N+2.
- Bypass and scoreboard:
  - Issue rd=10 -> rs1_busy_o=1 for rs1_i=10 from the next cycle.
  - lt result rd=10, data 32'h1234, FIFO empty, ex idle -> we_o at next cycle; busy[10]=0 the cycle after.
- Collision and order:
  - Issue rd=3,4,6. Then, with ex_valid_i=1 for 3 consecutive cycles, present lt results 3, 4, 6 back-to-back.
  - Expected: lt_ready_o=0 when 2 are buffered; writes order ex, ex, ex, 3, 4, 6; no result lost.
- rd=0 and same-cycle set/clear:
  - lt result rd=0 -> consumed, we_o stays 0, waw_err_o=0.
  - Issue rd=7 on the cycle a write to 7 completes -> busy[7] remains 1.
- Hazard errors and reset:
  - Issue rd=9 twice -> waw_err_o=1, sticky.
  - rst mid-FIFO (2 entries held) -> FIFO empty, we_o=0 next cycle, busy cleared.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared widths and write-back source encoding for the GPR write-back arbiter.
package wb_arb_pkg;

`ifdef RV32E_BASE_ISA
   localparam int REG_NUM_DEF = 16;
`else
   localparam int REG_NUM_DEF = 32;
`endif

   localparam int REG_ADDR_BUS = 5;
   localparam int REG_BUS      = 32;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_EX   = 2'd1,
      SRC_FIFO = 2'd2,
      SRC_BYP  = 2'd3
   } wb_src_e;

endpackage

// File: rtl/wb_arb_if.sv
// Bundle of execute, long-latency, GPR write and decode-hazard signals around wb_arb.
interface wb_arb_if
   import wb_arb_pkg::*;
#(
   parameter int AW = REG_ADDR_BUS,
   parameter int DW = REG_BUS
);
   logic          ex_valid_i;
   logic [AW-1:0] ex_rd_i;
   logic [DW-1:0] ex_data_i;
   logic          lt_issue_i;
   logic [AW-1:0] lt_issue_rd_i;
   logic          lt_valid_i;
   logic          lt_ready_o;
   logic [AW-1:0] lt_rd_i;
   logic [DW-1:0] lt_data_i;
   logic          we_o;
   logic [AW-1:0] waddr_o;
   logic [DW-1:0] wdata_o;
   logic [AW-1:0] rs1_i;
   logic [AW-1:0] rs2_i;
   logic          rs1_busy_o;
   logic          rs2_busy_o;
   logic          waw_err_o;

   modport slave (
      input  ex_valid_i, ex_rd_i, ex_data_i, lt_issue_i, lt_issue_rd_i,
             lt_valid_i, lt_rd_i, lt_data_i, rs1_i, rs2_i,
      output lt_ready_o, we_o, waddr_o, wdata_o, rs1_busy_o, rs2_busy_o, waw_err_o
   );

   modport master (
      output ex_valid_i, ex_rd_i, ex_data_i, lt_issue_i, lt_issue_rd_i,
             lt_valid_i, lt_rd_i, lt_data_i, rs1_i, rs2_i,
      input  lt_ready_o, we_o, waddr_o, wdata_o, rs1_busy_o, rs2_busy_o, waw_err_o
   );
endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering long-latency results; DEPTH must be a power of two.
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 37
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign dout    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/wb_arb.sv
// GPR write-back arbiter: merges execute and long-latency results into one registered
// write per cycle and tracks pending long-latency destinations for decode stalls.
module wb_arb
   import wb_arb_pkg::*;
#(
   parameter int REG_NUM    = REG_NUM_DEF,
   parameter int AW         = REG_ADDR_BUS,
   parameter int DW         = REG_BUS,
   parameter int FIFO_DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   wb_arb_if.slave bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [CW-1:0]    fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic [AW+DW-1:0] fifo_dout;
   logic             fifo_push;
   logic             fifo_pop;
   logic             lt_ready;
   logic             lt_acc;

   wb_src_e          sel;
   logic [AW-1:0]    sel_rd;
   logic [DW-1:0]    sel_data;

   logic             we_q;
   logic             wb_lt_q;
   logic [AW-1:0]    waddr_q;
   logic [DW-1:0]    wdata_q;
   logic             err_q;
   logic             err_set;
   logic [REG_NUM-1:0] busy_q;
   logic [REG_NUM-1:0] busy_nxt;

   wb_fifo #(.DEPTH(FIFO_DEPTH), .W(AW + DW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({bus.lt_rd_i, bus.lt_data_i}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign lt_ready = (fifo_count < CW'(FIFO_DEPTH));
   assign lt_acc   = bus.lt_valid_i && lt_ready;

   always_comb begin
      sel      = SRC_NONE;
      sel_rd   = '0;
      sel_data = '0;
      if (bus.ex_valid_i) begin
         sel      = SRC_EX;
         sel_rd   = bus.ex_rd_i;
         sel_data = bus.ex_data_i;
      end else if (!fifo_empty) begin
         sel      = SRC_FIFO;
         {sel_rd, sel_data} = fifo_dout;
      end else if (lt_acc) begin
         sel      = SRC_BYP;
         sel_rd   = bus.lt_rd_i;
         sel_data = bus.lt_data_i;
      end
   end

   assign fifo_pop  = (sel == SRC_FIFO);
   assign fifo_push = lt_acc && (sel != SRC_BYP) && !fifo_full;

   // rd=0 entries are consumed but never produce a GPR write.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         wb_lt_q <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q    <= (sel != SRC_NONE) && (sel_rd != '0);
         wb_lt_q <= (sel == SRC_FIFO) || (sel == SRC_BYP);
         if (sel != SRC_NONE) begin
            waddr_q <= sel_rd;
            wdata_q <= sel_data;
         end
      end
   end

   // Clear lands on the GPR write edge; a same-cycle issue to that register wins.
   always_comb begin
      busy_nxt = busy_q;
      if (we_q && wb_lt_q) busy_nxt[waddr_q] = 1'b0;
      if (bus.lt_issue_i && (bus.lt_issue_rd_i != '0)) busy_nxt[bus.lt_issue_rd_i] = 1'b1;
   end

   assign err_set = (bus.lt_issue_i && busy_q[bus.lt_issue_rd_i])
                 || (bus.ex_valid_i && busy_q[bus.ex_rd_i])
                 || (lt_acc && (bus.lt_rd_i != '0) && !busy_q[bus.lt_rd_i]);

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_nxt;
         err_q  <= err_q || err_set;
      end
   end

   assign bus.lt_ready_o = lt_ready;
   assign bus.we_o       = we_q;
   assign bus.waddr_o    = waddr_q;
   assign bus.wdata_o    = wdata_q;
   assign bus.waw_err_o  = err_q;
   assign bus.rs1_busy_o = (bus.rs1_i != '0) && busy_q[bus.rs1_i];
   assign bus.rs2_busy_o = (bus.rs2_i != '0) && busy_q[bus.rs2_i];
endmodule

// File: tb/tb_wb_arb.sv
// Directed bench for wb_arb: expected GPR writes go into a queue at stimulus time and a
// negedge monitor pops and compares them whenever we_o is asserted.
module tb_wb_arb;
   import wb_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_arb_if #(.AW(5), .DW(32)) bus ();

   wb_arb #(.REG_NUM(32), .AW(5), .DW(32), .FIFO_DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
      wr_t e;
      e.rd   = rd;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (bus.we_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                     bus.waddr_o, bus.wdata_o);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {27'b0, bus.waddr_o}, {27'b0, e.rd});
            chk("wr_data", bus.wdata_o, e.data);
         end
      end
   end

   initial begin
      bus.ex_valid_i    = 1'b1;
      bus.ex_rd_i       = 5'd5;
      bus.ex_data_i     = 32'h1;
      bus.lt_issue_i    = 1'b0;
      bus.lt_issue_rd_i = '0;
      bus.lt_valid_i    = 1'b0;
      bus.lt_rd_i       = '0;
      bus.lt_data_i     = '0;
      bus.rs1_i         = 5'd10;
      bus.rs2_i         = 5'd31;

      // reset held two cycles with execute traffic present
      rst = 1'b1;
      tick();
      tick();
      chk("rst_we", {31'b0, bus.we_o}, 32'd0);
      chk("rst_ready", {31'b0, bus.lt_ready_o}, 32'd1);
      chk("rst_busy1", {31'b0, bus.rs1_busy_o}, 32'd0);
      chk("rst_busy2", {31'b0, bus.rs2_busy_o}, 32'd0);
      chk("rst_err", {31'b0, bus.waw_err_o}, 32'd0);
      rst = 1'b0;
      bus.ex_valid_i = 1'b0;
      tick();

      // execute only
      bus.ex_valid_i = 1'b1;
      bus.ex_rd_i    = 5'd5;
      bus.ex_data_i  = 32'hDEADBEEF;
      expect_wr(5'd5, 32'hDEADBEEF);
      tick();
      bus.ex_valid_i = 1'b0;
      chk("ex_we_n1", {31'b0, bus.we_o}, 32'd1);
      tick();
      chk("ex_we_n2", {31'b0, bus.we_o}, 32'd0);

      // bypass and scoreboard
      bus.lt_issue_i    = 1'b1;
      bus.lt_issue_rd_i = 5'd10;
      tick();
      bus.lt_issue_i = 1'b0;
      bus.rs1_i      = 5'd10;
      bus.rs2_i      = 5'd0;
      #1;
      chk("issue10_busy", {31'b0, bus.rs1_busy_o}, 32'd1);
      chk("rs0_busy", {31'b0, bus.rs2_busy_o}, 32'd0);
      chk("byp_ready", {31'b0, bus.lt_ready_o}, 32'd1);
      bus.lt_valid_i = 1'b1;
      bus.lt_rd_i    = 5'd10;
      bus.lt_data_i  = 32'h1234;
      expect_wr(5'd10, 32'h1234);
      tick();
      bus.lt_valid_i = 1'b0;
      chk("byp_we", {31'b0, bus.we_o}, 32'd1);
      chk("byp_busy_held", {31'b0, bus.rs1_busy_o}, 32'd1);
      tick();
      chk("byp_busy_clr", {31'b0, bus.rs1_busy_o}, 32'd0);

      // collision: execute hogs the port while three long-latency results arrive
      bus.lt_issue_i = 1'b1;
      bus.lt_issue_rd_i = 5'd3; tick();
      bus.lt_issue_rd_i = 5'd4; tick();
      bus.lt_issue_rd_i = 5'd6; tick();
      bus.lt_issue_i = 1'b0;
      expect_wr(5'd11, 32'hA11);
      expect_wr(5'd12, 32'hA12);
      expect_wr(5'd13, 32'hA13);
      expect_wr(5'd3, 32'h300);
      expect_wr(5'd4, 32'h400);
      expect_wr(5'd6, 32'h600);
      bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd11; bus.ex_data_i = 32'hA11;
      bus.lt_valid_i = 1'b1; bus.lt_rd_i = 5'd3;  bus.lt_data_i = 32'h300;
      tick();
      bus.ex_rd_i = 5'd12; bus.ex_data_i = 32'hA12;
      bus.lt_rd_i = 5'd4;  bus.lt_data_i = 32'h400;
      tick();
      bus.ex_rd_i = 5'd13; bus.ex_data_i = 32'hA13;
      bus.lt_rd_i = 5'd6;  bus.lt_data_i = 32'h600;
      chk("full_ready_c2", {31'b0, bus.lt_ready_o}, 32'd0);
      tick();
      bus.ex_valid_i = 1'b0;
      chk("full_ready_c3", {31'b0, bus.lt_ready_o}, 32'd0);
      tick();
      chk("ready_after_pop", {31'b0, bus.lt_ready_o}, 32'd1);
      tick();
      bus.lt_valid_i = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      chk("collision_drain", exp_q.size(), 32'd0);
      tick();
      bus.rs1_i = 5'd6;
      bus.rs2_i = 5'd3;
      #1;
      chk("busy6_clr", {31'b0, bus.rs1_busy_o}, 32'd0);
      chk("busy3_clr", {31'b0, bus.rs2_busy_o}, 32'd0);

      // rd=0 result is consumed silently
      bus.lt_valid_i = 1'b1;
      bus.lt_rd_i    = 5'd0;
      bus.lt_data_i  = 32'h5555;
      tick();
      bus.lt_valid_i = 1'b0;
      chk("rd0_we", {31'b0, bus.we_o}, 32'd0);
      chk("rd0_err", {31'b0, bus.waw_err_o}, 32'd0);
      tick();

      // double issue to rd=9 raises a sticky hazard error
      bus.lt_issue_i    = 1'b1;
      bus.lt_issue_rd_i = 5'd9;
      tick();
      chk("waw_first", {31'b0, bus.waw_err_o}, 32'd0);
      tick();
      bus.lt_issue_i = 1'b0;
      chk("waw_second", {31'b0, bus.waw_err_o}, 32'd1);
      tick();
      tick();
      chk("waw_sticky", {31'b0, bus.waw_err_o}, 32'd1);

      // issue rd=7 on the same edge that a long-latency write to 7 clears it
      bus.lt_issue_i    = 1'b1;
      bus.lt_issue_rd_i = 5'd7;
      tick();
      bus.lt_issue_i = 1'b0;
      bus.lt_valid_i = 1'b1;
      bus.lt_rd_i    = 5'd7;
      bus.lt_data_i  = 32'h77;
      expect_wr(5'd7, 32'h77);
      tick();
      bus.lt_valid_i    = 1'b0;
      bus.lt_issue_i    = 1'b1;
      bus.lt_issue_rd_i = 5'd7;
      tick();
      bus.lt_issue_i = 1'b0;
      bus.rs1_i      = 5'd7;
      #1;
      chk("set_wins_busy7", {31'b0, bus.rs1_busy_o}, 32'd1);

      // reset with two results buffered
      bus.lt_issue_i = 1'b1;
      bus.lt_issue_rd_i = 5'd20; tick();
      bus.lt_issue_rd_i = 5'd21; tick();
      bus.lt_issue_i = 1'b0;
      expect_wr(5'd14, 32'hE14);
      expect_wr(5'd15, 32'hE15);
      bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd14; bus.ex_data_i = 32'hE14;
      bus.lt_valid_i = 1'b1; bus.lt_rd_i = 5'd20; bus.lt_data_i = 32'h2000;
      tick();
      bus.ex_rd_i = 5'd15; bus.ex_data_i = 32'hE15;
      bus.lt_rd_i = 5'd21; bus.lt_data_i = 32'h2100;
      tick();
      bus.ex_valid_i = 1'b0;
      bus.lt_valid_i = 1'b0;
      rst = 1'b1;
      chk("pre_rst_full", {31'b0, bus.lt_ready_o}, 32'd0);
      tick();
      rst = 1'b0;
      bus.rs1_i = 5'd20;
      bus.rs2_i = 5'd7;
      #1;
      chk("mid_rst_we", {31'b0, bus.we_o}, 32'd0);
      chk("mid_rst_ready", {31'b0, bus.lt_ready_o}, 32'd1);
      chk("mid_rst_err", {31'b0, bus.waw_err_o}, 32'd0);
      chk("mid_rst_busy20", {31'b0, bus.rs1_busy_o}, 32'd0);
      chk("mid_rst_busy7", {31'b0, bus.rs2_busy_o}, 32'd0);
      tick();
      chk("mid_rst_no_stale", {31'b0, bus.we_o}, 32'd0);
      tick();
      chk("final_queue_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
